// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial adder, DIGIT bits per clock, registered sum/cout/ovf
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] acc_next;
  logic             msb_cin;
  logic             last;

  // One digit of addition: the only arithmetic is this DIGIT+1 bit adder.
  always_comb begin
    dsum     = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    // Carry into the top bit of the digit, recovered from the operand and result bits.
    msb_cin  = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ dsum[DIGIT-1];
    // New digit enters at the MSB end; after STEPS shifts the sum is aligned.
    acc_next = (acc >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
    last     = (cnt == CW'(STEPS - 1));
  end

  // Control FSM with datapath shift registers and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          carry <= dsum[DIGIT];
          acc   <= acc_next;
          cnt   <= cnt + 1'b1;
          if (last) begin
            sum   <= acc_next;
            cout  <= dsum[DIGIT];
            ovf   <= msb_cin ^ dsum[DIGIT];
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder in three configurations
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Instance 0: WIDTH=8 DIGIT=1
  logic       start0 = 1'b0, cin0 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0;
  logic [7:0] sum0;
  logic       cout0, ovf0, busy0, done0;
  // Instance 1: WIDTH=8 DIGIT=4
  logic       start1 = 1'b0, cin1 = 1'b0;
  logic [7:0] a1 = '0, b1 = '0;
  logic [7:0] sum1;
  logic       cout1, ovf1, busy1, done1;
  // Instance 2: WIDTH=1 DIGIT=1
  logic       start2 = 1'b0, cin2 = 1'b0;
  logic [0:0] a2 = '0, b2 = '0;
  logic [0:0] sum2;
  logic       cout2, ovf2, busy2, done2;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  serial_adder #(.WIDTH(8), .DIGIT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .cin(cin0),
    .sum(sum0), .cout(cout0), .ovf(ovf0), .busy(busy0), .done(done0)
  );
  serial_adder #(.WIDTH(8), .DIGIT(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1), .done(done1)
  );
  serial_adder #(.WIDTH(1), .DIGIT(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .sum(sum2), .cout(cout2), .ovf(ovf2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int id, input logic [7:0] av, input logic [7:0] bv,
                                 input logic ci);
    exp_t e;
    logic [8:0] t;
    logic [1:0] t1;
    if (id == 2) begin
      t1     = {1'b0, av[0]} + {1'b0, bv[0]} + {1'b0, ci};
      e.sum  = {7'b0, t1[0]};
      e.cout = t1[1];
      e.ovf  = (av[0] == bv[0]) && (t1[0] != av[0]);
    end else begin
      t      = {1'b0, av} + {1'b0, bv} + {8'b0, ci};
      e.sum  = t[7:0];
      e.cout = t[8];
      e.ovf  = (av[7] == bv[7]) && (t[7] != av[7]);
    end
    return e;
  endfunction

  function automatic obs_t get_obs(input int id);
    obs_t o;
    case (id)
      0:       o = '{sum: sum0, cout: cout0, ovf: ovf0, busy: busy0, done: done0};
      1:       o = '{sum: sum1, cout: cout1, ovf: ovf1, busy: busy1, done: done1};
      default: o = '{sum: {7'b0, sum2}, cout: cout2, ovf: ovf2, busy: busy2, done: done2};
    endcase
    return o;
  endfunction

  task automatic drive(input int id, input logic st, input logic [7:0] av,
                       input logic [7:0] bv, input logic ci);
    case (id)
      0: begin start0 = st; a0 = av; b0 = bv; cin0 = ci; end
      1: begin start1 = st; a1 = av; b1 = bv; cin1 = ci; end
      default: begin start2 = st; a2 = av[0]; b2 = bv[0]; cin2 = ci; end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic check_result(input string tag, input obs_t o, input exp_t e);
    chk({tag, ".sum"},  32'(o.sum),  32'(e.sum));
    chk({tag, ".cout"}, 32'(o.cout), 32'(e.cout));
    chk({tag, ".ovf"},  32'(o.ovf),  32'(e.ovf));
  endtask

  // One addition; operands are scrambled right after acceptance to prove they are not resampled.
  task automatic run_op(input int id, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input int steps, input string tag);
    obs_t o;
    exp_t e;
    int   lat;
    bit   seen;
    @(negedge clk);
    drive(id, 1'b1, av, bv, ci);
    sb.push_back(model(id, av, bv, ci));
    @(negedge clk);
    drive(id, 1'b0, ~av, ~bv, ~ci);
    o = get_obs(id);
    chk({tag, ".busy_run"}, 32'(o.busy), 32'd1);
    chk({tag, ".done_early"}, 32'(o.done), 32'd0);
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= steps + 4; k++) begin
      @(negedge clk);
      o = get_obs(id);
      if (o.done) begin
        seen = 1'b1;
        lat  = k;
        break;
      end
    end
    chk({tag, ".latency"}, 32'(lat), 32'(steps));
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      check_result(tag, o, e);
      chk({tag, ".busy_done"}, 32'(o.busy), 32'd1);
    end else begin
      sb.delete();
    end
    @(negedge clk);
    o = get_obs(id);
    chk({tag, ".done_pulse"}, 32'(o.done), 32'd0);
    chk({tag, ".busy_idle"}, 32'(o.busy), 32'd0);
    drive(id, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  initial begin
    obs_t o;
    exp_t e;
    exp_t ex;
    int   ndone;
    int   cnt;

    // Reset state, checked without any clock edge having occurred yet.
    #1;
    for (int id = 0; id < 3; id++) chk($sformatf("reset%0d", id), 32'(get_obs(id)), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=8 DIGIT=1 directed and random additions.
    run_op(0, 8'hFF, 8'h01, 1'b0, 8, "w8d1_ff01");
    run_op(0, 8'h7F, 8'h01, 1'b0, 8, "w8d1_7f01");
    run_op(0, 8'h80, 8'h80, 1'b1, 8, "w8d1_8080");
    for (int i = 0; i < 4; i++)
      run_op(0, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 8, $sformatf("w8d1_rnd%0d", i));

    // WIDTH=8 DIGIT=4.
    run_op(1, 8'hA5, 8'h5A, 1'b1, 2, "w8d4_a55a");
    run_op(1, 8'h40, 8'h40, 1'b0, 2, "w8d4_4040");
    for (int i = 0; i < 3; i++)
      run_op(1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 2, $sformatf("w8d4_rnd%0d", i));

    // WIDTH=1 DIGIT=1: full adder truth table.
    run_op(2, 8'h01, 8'h01, 1'b1, 1, "w1_111");
    for (int v = 0; v < 8; v++)
      run_op(2, {7'b0, v[2]}, {7'b0, v[1]}, v[0], 1, $sformatf("w1_fa%0d", v));

    // start held high, operands changed mid-RUN: one done per 10 cycles, each result from its own accept.
    @(negedge clk);
    drive(0, 1'b1, 8'h3C, 8'h4B, 1'b1);
    ex = model(0, 8'h3C, 8'h4B, 1'b1);
    sb.push_back(ex);
    @(negedge clk);
    drive(0, 1'b1, 8'hC8, 8'h9A, 1'b0);
    sb.push_back(model(0, 8'hC8, 8'h9A, 1'b0));
    ndone = 0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k == 10) drive(0, 1'b0, 8'hC8, 8'h9A, 1'b0);
      o = get_obs(0);
      if (k == 12) chk("hold.sum", 32'(o.sum), 32'(ex.sum));
      if (o.done) begin
        ndone++;
        chk($sformatf("hold.done_pos%0d", ndone), 32'(k), (ndone == 1) ? 32'd8 : 32'd18);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_result($sformatf("hold.res%0d", ndone), o, e);
        end
      end
    end
    chk("hold.ndone", 32'(ndone), 32'd2);
    sb.delete();
    @(negedge clk);

    // Reset mid-RUN: outputs clear without a clock edge, no done follows.
    run_op(0, 8'h7F, 8'h01, 1'b0, 8, "pre_rst");
    @(negedge clk);
    drive(0, 1'b1, 8'h12, 8'h34, 1'b0);
    sb.push_back(model(0, 8'h12, 8'h34, 1'b0));
    @(negedge clk);
    drive(0, 1'b0, 8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);
    chk("abort.busy_before", 32'(busy0), 32'd1);
    chk("abort.sum_before", 32'(sum0), 32'h80);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.async_clear", 32'(get_obs(0)), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done0) cnt++;
    end
    chk("abort.no_done", 32'(cnt), 32'd0);
    run_op(0, 8'h12, 8'h34, 1'b0, 8, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning operand and sum width in bits (legal: WIDTH >= 1).
REQ-002 The module SHALL have parameter DIGIT, default 1, meaning bits added per clock cycle (legal: DIGIT >= 1, DIGIT divides WIDTH).
REQ-003 The module SHALL define local constant STEPS = WIDTH/DIGIT, meaning the number of digit cycles per addition.
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit, the reset; the reset SHALL be asynchronous and active-low.
REQ-006 The module SHALL have port start, input, 1 bit, the request to begin an addition.
REQ-007 The module SHALL have port a, input, WIDTH bits, the first operand.
REQ-008 The module SHALL have port b, input, WIDTH bits, the second operand.
REQ-009 The module SHALL have port cin, input, 1 bit, the carry-in.
REQ-010 The module SHALL have port sum, output, WIDTH bits, the result a+b+cin modulo 2^WIDTH.
REQ-011 The module SHALL have port cout, output, 1 bit, the unsigned carry-out of the result.
REQ-012 The module SHALL have port ovf, output, 1 bit, the two's-complement overflow flag: carry into MSB XOR carry out of MSB.
REQ-013 The module SHALL have port busy, output, 1 bit, high while an addition is in progress.
REQ-014 The module SHALL have port done, output, 1 bit, a one-cycle pulse marking sum/cout/ovf as newly valid.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 In IDLE, start=1 at a rising edge SHALL load a, b and cin into internal registers, clear the digit counter, and move to RUN; start=0 SHALL keep IDLE.
REQ-017 In RUN, each edge SHALL add the least-significant DIGIT bits of the a and b shift registers plus the carry register, shift the DIGIT-bit result into the sum shift register from the MSB end, store the new carry, shift a and b right by DIGIT, and increment the counter.
REQ-018 The edge that processes digit STEPS-1 SHALL move RUN to DONE and SHALL transfer the completed sum, final carry and computed ovf into the output registers in the same edge.
REQ-019 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-020 done SHALL be 1 only in DONE; busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-021 Latency SHALL be fixed: done is high in the cycle following the STEPS-th edge after the edge that sampled start.
REQ-022 sum, cout and ovf SHALL be registered, SHALL never show partial results, and SHALL hold their last completed value until the next DONE.
REQ-023 start SHALL be ignored in RUN and DONE; no request is queued, so the earliest new acceptance is the first IDLE cycle after done.
REQ-024 Operand inputs SHALL be sampled only at the accepting edge; later changes to a, b or cin SHALL NOT affect the addition in progress.
REQ-025 The internal carry and digit-sum logic SHALL be DIGIT+1 bits wide; no other arithmetic widening is permitted.
REQ-026 Arithmetic SHALL wrap modulo 2^WIDTH, with the lost bit reported on cout.
REQ-027 When DIGIT = WIDTH, STEPS SHALL be 1 and the addition SHALL complete in one RUN edge.
REQ-028 When WIDTH = DIGIT = 1, the block SHALL behave as a registered full adder.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for clk, force state IDLE and clear sum, cout, ovf, busy, done and all internal registers to 0.
REQ-030 An assertion of rst_n during RUN or DONE SHALL abort the addition; no done pulse SHALL follow the abort.
REQ-031 After rst_n is released, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-032 The bench SHALL cover: WIDTH=8, DIGIT=1; a=8'hFF, b=8'h01, cin=0, start pulsed -> busy high, done pulse 8 edges later, sum=8'h00, cout=1, ovf=0.
REQ-033 The bench SHALL cover: WIDTH=8, DIGIT=1; a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1.
REQ-034 The bench SHALL cover: WIDTH=8, DIGIT=4; a=8'hA5, b=8'h5A, cin=1 -> done pulse 2 edges after the accepting edge, sum=8'h00, cout=1, ovf=0.
REQ-035 The bench SHALL cover: start held high throughout and operands changed mid-RUN -> the first result is unaffected, with exactly one done per STEPS+2 cycles.
REQ-036 The bench SHALL cover: rst_n pulsed low mid-RUN -> all outputs are 0 asynchronously, no done pulse follows, and the next start yields a correct result.
REQ-037 The bench SHALL cover: WIDTH=1, DIGIT=1; a=1, b=1, cin=1 -> sum=1, cout=1, done 1 edge after the accepting edge.
